// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the 9-bit core: opcode constants, the ack
// instruction encoding and the sequencer state type.
//   Opcode field is Instr[8:5]; Instr[4:0] is the operand field.
package prog_sequencer_pkg;

    localparam int INSTR_W = 9;
    localparam int OPC_W   = 4;

    localparam logic [OPC_W-1:0] kLDI  = 4'b0100;
    localparam logic [OPC_W-1:0] kLDR  = 4'b0101;
    localparam logic [OPC_W-1:0] kSTR  = 4'b0110;
    localparam logic [OPC_W-1:0] kBNZ  = 4'b1010;
    localparam logic [OPC_W-1:0] kBNZR = 4'b1011;

    // All-ones word ends the program.
    localparam logic [INSTR_W-1:0] kACK = 9'h1FF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/prog_sequencer_mem_wait_timer.sv
// Memory wait timer: loadable down-counter that flags expiry at zero.
//   clk_i       in   clock
//   rst_n       in   async active-low reset (count cleared)
//   load_i      in   load load_val_i (asserted on MEM entry)
//   dec_i       in   count one wait cycle
//   load_val_i  in   start value
//   expired_o   out  count has reached zero
module prog_sequencer_mem_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/prog_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the program counter and the
// instruction register, qualifies decoder write strobes and stalls on the
// data-memory handshake.
//   clk_i, rst_n                clock, async active-low reset
//   start_i, start_addr_i       start request and entry point (IDLE/HALT only)
//   instr_in_i                  ROM data at prog_ctr_o
//   branch_taken_i/target_i     branch resolution from the datapath
//   mem_ack_i                   data memory completion
//   prog_ctr_o, instr_o         PC and instruction register
//   instr_valid_o               executing (EXEC or MEM)
//   reg_wr_gate_o               one-cycle commit strobe
//   mem_req_o, mem_we_o         data memory request / store qualifier
//   busy_o, done_o, error_o     status
//   cycle_count_o               busy cycles since last start, saturating
//
// state | meaning
// IDLE  | waiting for start after reset
// FETCH | latch ROM word into instr register
// EXEC  | execute instr; commit, branch, enter MEM or finish
// MEM   | wait for data memory ack, bounded by the timer
// HALT  | finished (done) or timed out (error); start restarts
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int PC_W        = 10,
    parameter int START_ADDR  = 0,
    parameter int MEM_TIMEOUT = 15,
    parameter int CYC_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [PC_W-1:0]    start_addr_i,
    input  logic [INSTR_W-1:0] instr_in_i,
    input  logic               branch_taken_i,
    input  logic [PC_W-1:0]    branch_target_i,
    input  logic               mem_ack_i,
    output logic [PC_W-1:0]    prog_ctr_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    output logic               reg_wr_gate_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic [CYC_W-1:0]   cycle_count_o
);

    seq_state_e         state_q;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [CYC_W-1:0]   cyc_q;
    logic               done_q;
    logic               error_q;

    logic [OPC_W-1:0]   opc;
    logic               is_ack;
    logic               is_mem;
    logic               is_branch;
    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_expired;

    prog_sequencer_mem_wait_timer #(
        .W (8)
    ) u_mem_wait_timer (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .dec_i      (tmr_dec),
        .load_val_i (8'(MEM_TIMEOUT)),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        opc           = instr_q[INSTR_W-1 -: OPC_W];
        is_ack        = (instr_q == kACK);
        is_mem        = (opc == kLDR) || (opc == kSTR);
        is_branch     = (opc == kBNZ) || (opc == kBNZR);
        instr_valid_o = 1'b0;
        reg_wr_gate_o = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        busy_o        = 1'b0;
        tmr_load      = 1'b0;
        tmr_dec       = 1'b0;
        case (state_q)
            S_FETCH: begin
                busy_o = 1'b1;
            end
            S_EXEC: begin
                busy_o        = 1'b1;
                instr_valid_o = 1'b1;
                reg_wr_gate_o = !is_ack && !is_mem;
                tmr_load      = !is_ack && is_mem;
            end
            S_MEM: begin
                busy_o        = 1'b1;
                instr_valid_o = 1'b1;
                mem_req_o     = 1'b1;
                mem_we_o      = (opc == kSTR);
                // The only input-to-output path: commit coincides with the ack.
                reg_wr_gate_o = mem_ack_i;
                tmr_dec       = !mem_ack_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_W'(START_ADDR);
            instr_q <= '0;
            cyc_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (busy_o && cyc_q != '1) begin
                cyc_q <= cyc_q + CYC_W'(1);
            end
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start_i) begin
                        pc_q    <= start_addr_i;
                        cyc_q   <= '0;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    instr_q <= instr_in_i;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_ack) begin
                        done_q  <= 1'b1;
                        state_q <= S_HALT;
                    end else if (is_mem) begin
                        state_q <= S_MEM;
                    end else begin
                        pc_q    <= (is_branch && branch_taken_i) ? branch_target_i
                                                                 : pc_q + PC_W'(1);
                        state_q <= S_FETCH;
                    end
                end
                S_MEM: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (mem_ack_i) begin
                        pc_q    <= pc_q + PC_W'(1);
                        state_q <= S_FETCH;
                    end else if (tmr_expired) begin
                        error_q <= 1'b1;
                        state_q <= S_HALT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign prog_ctr_o    = pc_q;
    assign instr_o       = instr_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign cycle_count_o = cyc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;
    import prog_sequencer_pkg::*;

    localparam int PC_W = 10;
    localparam int DEPTH = 1 << PC_W;
    localparam int T_OUT = 15;
    localparam int NEVER = 1000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic [PC_W-1:0] start_addr_i = '0;
    logic [8:0]      instr_in_i;
    logic            branch_taken_i;
    logic [PC_W-1:0] branch_target_i;
    logic            mem_ack_i;
    logic [PC_W-1:0] prog_ctr_o;
    logic [8:0]      instr_o;
    logic            instr_valid_o, reg_wr_gate_o, mem_req_o, mem_we_o;
    logic            busy_o, done_o, error_o;
    logic [15:0]     cycle_count_o;

    prog_sequencer #(
        .PC_W(PC_W), .START_ADDR(0), .MEM_TIMEOUT(T_OUT), .CYC_W(16)
    ) dut (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_i), .start_addr_i(start_addr_i),
        .instr_in_i(instr_in_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .mem_ack_i(mem_ack_i),
        .prog_ctr_o(prog_ctr_o), .instr_o(instr_o), .instr_valid_o(instr_valid_o),
        .reg_wr_gate_o(reg_wr_gate_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .cycle_count_o(cycle_count_o)
    );

    always #5 clk = ~clk;

    // Environment: ROM, branch resolution and memory responder tables.
    logic [8:0]      rom       [DEPTH];
    bit              bt_taken  [DEPTH];
    logic [PC_W-1:0] bt_target [DEPTH];
    int              ack_wait  [DEPTH];
    int              wait_cnt;

    always_comb begin
        instr_in_i      = rom[prog_ctr_o];
        branch_taken_i  = bt_taken[prog_ctr_o];
        branch_target_i = bt_target[prog_ctr_o];
        mem_ack_i       = mem_req_o && (wait_cnt == ack_wait[prog_ctr_o]);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (mem_req_o && !mem_ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected per-cycle trace, generated instruction by instruction.
    typedef struct {
        int pc; int instr; int cc;
        bit busy; bit valid; bit req; bit we; bit gate; bit done; bit err;
    } rec_t;
    rec_t exp_q[$];

    task automatic push(input int pc, input int instr, input int cc, input bit busy,
                        input bit valid, input bit req, input bit we, input bit gate,
                        input bit done, input bit err);
        rec_t r;
        r.pc = pc; r.instr = instr; r.cc = cc; r.busy = busy; r.valid = valid;
        r.req = req; r.we = we; r.gate = gate; r.done = done; r.err = err;
        exp_q.push_back(r);
    endtask

    task automatic build(input int sa);
        int pc = sa;
        int cc = 0;
        int ins;
        int op;
        int w;
        bit fin = 0;
        exp_q.delete();
        for (int step = 0; step < 100 && !fin; step++) begin
            push(pc, 0, cc, 1, 0, 0, 0, 0, 0, 0);
            cc++;
            ins = int'(rom[pc]);
            op = ins >> 5;
            if (ins == 'h1FF) begin
                push(pc, ins, cc, 1, 1, 0, 0, 0, 0, 0);
                cc++;
                repeat (2) push(pc, ins, cc, 0, 0, 0, 0, 0, 1, 0);
                fin = 1;
            end else if (op == int'(kLDR) || op == int'(kSTR)) begin
                push(pc, ins, cc, 1, 1, 0, 0, 0, 0, 0);
                cc++;
                w = ack_wait[pc];
                if (w <= T_OUT) begin
                    for (int i = 0; i <= w; i++) begin
                        push(pc, ins, cc, 1, 1, 1, op == int'(kSTR), i == w, 0, 0);
                        cc++;
                    end
                    pc = (pc + 1) % DEPTH;
                end else begin
                    for (int i = 0; i <= T_OUT; i++) begin
                        push(pc, ins, cc, 1, 1, 1, op == int'(kSTR), 0, 0, 0);
                        cc++;
                    end
                    repeat (2) push(pc, ins, cc, 0, 0, 0, 0, 0, 0, 1);
                    fin = 1;
                end
            end else begin
                push(pc, ins, cc, 1, 1, 0, 0, 1, 0, 0);
                cc++;
                if ((op == int'(kBNZ) || op == int'(kBNZR)) && bt_taken[pc])
                    pc = int'(bt_target[pc]);
                else
                    pc = (pc + 1) % DEPTH;
            end
        end
    endtask

    bit checking = 0;
    int mem_cycles = 0;
    int gate_pulses = 0;

    always @(negedge clk) begin
        rec_t r;
        if (checking && exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check("pc", int'(prog_ctr_o), r.pc);
            check("busy", int'(busy_o), int'(r.busy));
            check("instr_valid", int'(instr_valid_o), int'(r.valid));
            check("mem_req", int'(mem_req_o), int'(r.req));
            check("mem_we", int'(mem_we_o), int'(r.we));
            check("reg_wr_gate", int'(reg_wr_gate_o), int'(r.gate));
            check("cycle_count", int'(cycle_count_o), r.cc);
            check("done", int'(done_o), int'(r.done));
            check("error", int'(error_o), int'(r.err));
            if (r.valid) check("instr", int'(instr_o), r.instr);
        end
        if (mem_req_o) mem_cycles++;
        if (reg_wr_gate_o) gate_pulses++;
    end

    task automatic run(input int sa, input bit poke_busy);
        int i;
        build(sa);
        @(negedge clk);
        mem_cycles = 0;
        gate_pulses = 0;
        start_i = 1'b1;
        start_addr_i = PC_W'(sa);
        @(posedge clk);
        #1 start_i = 1'b0;
        checking = 1;
        if (poke_busy) begin
            repeat (2) @(negedge clk);
            start_i = 1'b1;
            start_addr_i = 10'd100;
            @(negedge clk);
            start_i = 1'b0;
        end
        for (i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL run_timeout: %0d records left, start %0d", exp_q.size(), sa);
        end
        checking = 0;
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            rom[a] = 9'h003;
            bt_taken[a] = 0;
            bt_target[a] = '0;
            ack_wait[a] = 0;
        end
        rom[5] = 9'h003; rom[6] = 9'h011; rom[7] = kACK;
        rom[30] = {kLDR, 5'd1}; ack_wait[30] = 3;
        rom[31] = {kSTR, 5'd2}; ack_wait[31] = 0;
        rom[32] = kACK;
        rom[20] = {kBNZR, 5'd4}; rom[3] = kACK; rom[21] = kACK;
        rom[1023] = 9'h005; bt_taken[1023] = 1; bt_target[1023] = 10'd500;
        rom[0] = kACK;
        rom[40] = {kLDR, 5'd3}; ack_wait[40] = NEVER;
        rom[50] = {kSTR, 5'd4}; ack_wait[50] = T_OUT; rom[51] = kACK;

        // Reset state.
        #12;
        check("rst_pc", int'(prog_ctr_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_instr", int'(instr_o), 0);
        check("rst_cc", int'(cycle_count_o), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy_o), 0);

        // Two ALU ops then ack, with an ignored start while busy.
        run(5, 1);
        check("a_pc", int'(prog_ctr_o), 7);
        check("a_cc", int'(cycle_count_o), 6);
        check("a_done", int'(done_o), 1);
        check("a_gates", gate_pulses, 2);

        // Load with three wait cycles, then a same-cycle-ack store.
        run(30, 0);
        check("b_pc", int'(prog_ctr_o), 32);
        check("b_cc", int'(cycle_count_o), 11);
        check("b_memcyc", mem_cycles, 5);
        check("b_gates", gate_pulses, 2);

        bt_taken[20] = 1; bt_target[20] = 10'd3;
        run(20, 0);
        check("c_pc", int'(prog_ctr_o), 3);
        check("c_cc", int'(cycle_count_o), 4);

        bt_taken[20] = 0;
        run(20, 0);
        check("d_pc", int'(prog_ctr_o), 21);

        // Non-branch at the top address wraps; branch inputs ignored.
        run(1023, 0);
        check("e_pc", int'(prog_ctr_o), 0);
        check("e_done", int'(done_o), 1);

        // Memory never answers.
        run(40, 0);
        check("f_err", int'(error_o), 1);
        check("f_done", int'(done_o), 0);
        check("f_memcyc", mem_cycles, T_OUT + 1);
        check("f_gates", gate_pulses, 0);
        check("f_cc", int'(cycle_count_o), T_OUT + 3);

        // Ack on the last allowed cycle; start from HALT clears error.
        run(50, 0);
        check("g_err", int'(error_o), 0);
        check("g_done", int'(done_o), 1);
        check("g_memcyc", mem_cycles, T_OUT + 1);
        check("g_pc", int'(prog_ctr_o), 51);
        check("g_cc", int'(cycle_count_o), T_OUT + 5);

        // Asynchronous reset in the middle of a memory wait.
        @(negedge clk);
        start_i = 1'b1;
        start_addr_i = 10'd40;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("h_req_before", int'(mem_req_o), 1);
        rst_n = 1'b0;
        #1;
        check("h_req_async", int'(mem_req_o), 0);
        check("h_gate_async", int'(reg_wr_gate_o), 0);
        check("h_busy_async", int'(busy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("h_pc", int'(prog_ctr_o), 0);
        check("h_instr", int'(instr_o), 0);
        check("h_cc", int'(cycle_count_o), 0);
        check("h_done", int'(done_o), 0);
        check("h_err", int'(error_o), 0);
        check("h_valid", int'(instr_valid_o), 0);
        check("h_we", int'(mem_we_o), 0);
        check("h_busy", int'(busy_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Multi-cycle fetch/execute sequencer for the 9-bit core. It owns the program counter and the instruction register, and feeds the latched instruction to the `Ctrl` decoder. It qualifies decoder write strobes so each instruction commits exactly once, and stalls on data-memory handshakes. It sits between the instruction ROM, the datapath (branch resolution, data memory) and the testbench start/done interface.

## Interface
Parameters:
- PC_W, 10, program counter width; instruction ROM depth is 2^PC_W.
- START_ADDR, 0, ProgCtr value after reset.
- MEM_TIMEOUT, 15, maximum cycles in MEM without MemAck before an error halt (1..255).
- CYC_W, 16, width of the cycle counter.

Ports:
- Clk  in  1  the single clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  begin execution at StartAddr; honored only in IDLE or HALT.
- StartAddr  in  PC_W  entry point loaded on an accepted Start.
- InstrIn  in  9  instruction ROM data at ProgCtr; combinational ROM.
- BranchTaken  in  1  datapath branch condition (nonzero test) for the instruction in Instr.
- BranchTarget  in  PC_W  resolved target (LUT or register offset selected by the datapath).
- MemAck  in  1  data memory has completed the outstanding request.
- ProgCtr  out  PC_W  program counter, drives the ROM address.
- Instr  out  9  instruction register, drives the `Ctrl` decoder.
- InstrValid  out  1  Instr is being executed (EXEC or MEM).
- RegWrGate  out  1  one-cycle commit strobe; the datapath ANDs it with RegWrEn.
- MemReq  out  1  data memory request, held high until MemAck.
- MemWe  out  1  request is a store; valid only while MemReq is high.
- Busy  out  1  state is FETCH, EXEC or MEM.
- Done  out  1  program reached the ack instruction; level until the next accepted Start.
- Error  out  1  memory timeout occurred; level until the next accepted Start.
- CycleCount  out  CYC_W  cycles spent Busy since the last accepted Start; saturating.

## Operation
- States: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE
  - On Start: ProgCtr←StartAddr, CycleCount←0, Done←0, Error←0, go to FETCH.
  - Otherwise remain in IDLE.
- FETCH
  - Instr←InstrIn, go to EXEC.
- EXEC (InstrValid=1), in priority order:
  - Instr==9'h1FF: Done←1, go to HALT; ProgCtr unchanged.
  - Opcode kLDR or kSTR: go to MEM, clear the timeout counter.
  - Otherwise: RegWrGate=1, then
    - ProgCtr←BranchTarget if the opcode is kBNZ or kBNZR and BranchTaken=1;
    - else ProgCtr←ProgCtr+1;
    - go to FETCH.
- MEM (InstrValid=1, MemReq=1, MemWe=(opcode==kSTR))
  - MemAck=1: RegWrGate=1 (the decoder suppresses the write for a store), ProgCtr←ProgCtr+1, go to FETCH.
  - Else, timeout counter reaches MEM_TIMEOUT: Error←1, go to HALT.
  - Else: increment the timeout counter.
  - MemAck and the timeout in the same cycle: the ack wins.
- HALT
  - Busy=0; Done or Error held.
  - Start behaves as in IDLE.
- Start while Busy is ignored.
- MemAck outside MEM is ignored.
- BranchTaken and BranchTarget are ignored for non-branch opcodes.
- ProgCtr arithmetic wraps modulo 2^PC_W.
- CycleCount increments in every FETCH, EXEC and MEM cycle and saturates at all-ones.

## Timing
- Reset values:
  - state=IDLE, ProgCtr=START_ADDR, Instr=0, CycleCount=0, Done=0, Error=0, timeout counter=0.
  - All combinational outputs are therefore 0.
- Combinational outputs are Moore-style decodes of state and Instr, with no input-to-output paths:
  - InstrValid, RegWrGate, MemReq, MemWe, Busy.
  - Exception: RegWrGate in MEM equals MemAck.
- Latency per instruction:
  - non-memory: 2 cycles;
  - memory: 3 cycles with same-cycle MemAck, plus 1 per wait cycle;
  - ack instruction: Done rises on the edge ending its EXEC cycle.
- Start→first ProgCtr=StartAddr: 1 edge.
- Reset_n asserted mid-instruction drops MemReq and RegWrGate immediately (asynchronously); no commit occurs.

## Structure
- State enum and the constants below go in the shared `definitions` package, next to the existing opcode constants (kLDR, kLDI, kBNZR):
  - kSTR = 4'b0110;
  - kBNZ;
  - kACK = 9'h1FF.
- Natural sub-module: `mem_wait_timer`.
  - Loadable down-counter with a timeout flag, cleared on MEM entry.
- Everything else lives in one always_ff block plus one always_comb block.

## Test plan
- Reset_n low mid-MEM → MemReq=0 immediately; after release, ProgCtr=START_ADDR, state IDLE, all outputs 0.
- Start with StartAddr=5, ROM holds two ALU ops then 9'h1FF → ProgCtr 5,6,7; one RegWrGate pulse each for 5 and 6; Done=1 after 6 cycles; CycleCount=6.
- kLDR with MemAck delayed 3 cycles → MemReq high for 4 cycles, MemWe=0, RegWrGate coincides with MemAck; kSTR variant → MemWe=1 throughout.
- kBNZR at PC=20:
  - BranchTaken=1, BranchTarget=3 → next fetch from 3;
  - BranchTaken=0 → next fetch from 21;
  - PC=2^PC_W−1 non-branch → wraps to 0.
- MemAck never arrives → Error=1 after exactly MEM_TIMEOUT+1 MEM cycles, no RegWrGate; MemAck on the final cycle → normal completion, Error=0.
- Start pulsed while Busy → ignored; Start in HALT → restarts and clears Done, Error and CycleCount.
